nes_pad_poller: RTL
===================

# nes_pad_poller

Host-side poller for physical NES-style serial pads. It drives the shared latch and clock lines and shifts in two pads' active-low serial data. It presents the result as active-high button vectors in the core's `{R,L,D,U,Start,Select,B,A}` order, ready to feed the emulated-controller shift registers in place of the direct parallel-pin sampling. It runs in the fast system clock domain and polls on a fixed tick schedule, or immediately on request.

## Interface
Parameters:
- `TICK_DIV`, default 126: `clk` cycles per protocol tick. The default is about 6 µs at 21 MHz.
- `POLL_TICKS`, default 2778: ticks between automatic polls. The default is about 16.7 ms.
- `NUM_BITS`, default 8: bits per pad, range 8..16. Use 8 for NES, 16 for SNES.

Ports:
- `clk`, in, 1: system clock. All logic is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `poll_req`, in, 1: one-cycle pulse that requests an immediate poll.
- `pad_data1`, in, 1: pad 1 serial data, active-low, asynchronous.
- `pad_data2`, in, 1: pad 2 serial data, active-low, asynchronous.
- `pad_latch`, out, 1: latch line to both pads. Active-high.
- `pad_clk`, out, 1: shift clock to both pads. Idles high; pads shift on its rising edge.
- `buttons1`, out, NUM_BITS: pad 1 buttons, active-high. Bit 0 is the first bit shifted (A).
- `buttons2`, out, NUM_BITS: pad 2 buttons, same format as `buttons1`.
- `buttons_valid`, out, 1: one-cycle pulse when `buttons1` and `buttons2` update.
- `busy`, out, 1: high from LATCH entry until the return to IDLE.

## Operation
- **Prescaler.** Free-running counter 0..TICK_DIV-1. `tick` is asserted for one cycle when the count equals TICK_DIV-1. The FSM changes state only on `tick`.
- **Poll timer.** Counts ticks from POLL_TICKS-1 down to 0, then reloads. Reaching 0 sets `pending`.
- **Poll request.** `poll_req` also sets `pending`. Requests merge into the single `pending` flag; they are never queued.
- **Input synchronisers.** `pad_data1` and `pad_data2` each pass through a 2-flop synchroniser. All sampling uses the synchronised values.
- **States:**
  - IDLE: latch=0, clk=1. On `tick` with `pending`=1: clear `pending`, clear bit counter, go to LATCH.
  - LATCH: latch=1, clk=1. Lasts 2 ticks, then SETTLE.
  - SETTLE: latch=0, clk=1. Lasts 1 tick. On the ending tick, sample bit 0 from both pads, then go to CLK_LO.
  - CLK_LO: clk=0. Lasts 1 tick, then CLK_HI.
  - CLK_HI: clk=1. Lasts 1 tick. On the ending tick:
    - If counter < NUM_BITS-1: increment the counter, sample bit[counter+1], go to CLK_LO.
    - Otherwise: load the button outputs, pulse `buttons_valid`, go to IDLE.
- **Clock pulses.** Exactly NUM_BITS low pulses are issued per poll. The final pulse's shift result is discarded.
- **Sample storage.** Each sample is stored inverted: `shift1[i]` = ~sync1, `shift2[i]` = ~sync2. `buttons1` and `buttons2` take `shift1`/`shift2` as a whole; bits never change individually.
- **Requests while busy.** A `poll_req` or timer expiry during a poll sets `pending`. The next poll then starts on the first tick after IDLE is re-entered.
- **Disconnected pad.** The data line floats high, reads as 1, and therefore reports 0 (no buttons pressed). This is not an error.

## Timing
- **Reset values:** state IDLE, `pad_latch`=0, `pad_clk`=1, `buttons1`/`buttons2`=0, `buttons_valid`=0, `busy`=0, prescaler=0, poll timer=0, `pending`=0, synchronisers=1. Because the timer resets to 0, the first poll begins on the second tick after reset release.
- **Poll duration:** (3 + 2·NUM_BITS) ticks from LATCH entry to the IDLE return. For NUM_BITS=8 this is 19 ticks.
- **Output update:** `pad_latch`, `pad_clk` and `busy` are registered and change in the cycle after `tick`. `buttons*` and `buttons_valid` update in the same cycle.
- **Sampling margin:** each sample is taken at least one tick after the last pad_clk rising edge or latch fall. This covers the 2-cycle synchroniser delay when TICK_DIV ≥ 4, so TICK_DIV < 4 is unsupported.
- **Bus stability:** `buttons*` hold their previous value throughout a poll, so consumers never see a partial vector.
- **Reset mid-poll:** all outputs go immediately to their reset values. A partial shift is discarded.

## Test plan
Each bench instantiates two behavioural pad models. Each model loads ~pattern on latch high, drives bit0, and shifts right on a `pad_clk` rising edge, shifting in 1.

1. **NES poll.** TICK_DIV=4, NUM_BITS=8, pad1=8'h81, pad2=8'h5A. Required response:
   - After reset, a `buttons_valid` pulse with buttons1=8'h81 and buttons2=8'h5A.
   - Latch high for exactly 8 cycles.
   - Exactly 8 `pad_clk` low pulses, each 4 cycles wide.
   - `busy` high for 76 cycles.
2. **Disconnected pad.** pad_data2 tied to 1 -> buttons2=8'h00 on every valid pulse.
3. **Request while busy.** `poll_req` mid-poll, pad1 pattern changed from 8'h01 to 8'h10 during the poll -> the first valid carries the old value (8'h01). A second poll starts 1 tick after IDLE and reports 8'h10. Two poll_req pulses merge into one poll.
4. **Automatic polling.** POLL_TICKS=40, no `poll_req` -> successive `buttons_valid` pulses exactly 160 cycles apart.
5. **Reset mid-poll.** `reset_n` asserted in CLK_LO of bit 3 -> `pad_latch`=0, `pad_clk`=1 and `buttons1` cleared to 0 asynchronously. After release, a full poll is repeated.
6. **SNES width.** NUM_BITS=16, pad1=16'hF00F -> buttons1=16'hF00F, 16 clock pulses, poll length 35 ticks.

Source files
------------

// File: rtl/nes_pad_poller.sv
// Polls two NES/SNES serial pads on a tick schedule or on request; reports active-high button vectors.
// Outputs are registered one cycle after a tick; no backpressure, and overlapping requests merge into one poll.
module nes_pad_poller #(
  parameter int TICK_DIV   = 126,
  parameter int POLL_TICKS = 2778,
  parameter int NUM_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                poll_req,
  input  logic                pad_data1,
  input  logic                pad_data2,
  output logic                pad_latch,
  output logic                pad_clk,
  output logic [NUM_BITS-1:0] buttons1,
  output logic [NUM_BITS-1:0] buttons2,
  output logic                buttons_valid,
  output logic                busy
);

  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int TM_W  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam int CNT_W = $clog2(NUM_BITS);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [TM_W-1:0]  TM_LOAD  = TM_W'(POLL_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_CLK_LO,
    S_CLK_HI
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     ps_q, ps_d;
  logic [TM_W-1:0]     tmr_q, tmr_d;
  logic                pending_q, pending_d;
  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic                phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] shift1_q, shift1_d;
  logic [NUM_BITS-1:0] shift2_q, shift2_d;
  logic [NUM_BITS-1:0] buttons1_q, buttons1_d;
  logic [NUM_BITS-1:0] buttons2_q, buttons2_d;
  logic                valid_q, valid_d;
  logic                pad_latch_q, pad_latch_d;
  logic                pad_clk_q, pad_clk_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic                timer_hit;
  logic [CNT_W-1:0]    nxt_idx;

  assign tick    = (ps_q == PS_LAST);
  assign nxt_idx = cnt_q + CNT_W'(1);

  always_comb begin
    ps_d       = tick ? '0 : ps_q + PS_W'(1);
    tmr_d      = tmr_q;
    pending_d  = pending_q;
    sync1_d    = {sync1_q[0], pad_data1};
    sync2_d    = {sync2_q[0], pad_data2};
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    shift1_d   = shift1_q;
    shift2_d   = shift2_q;
    buttons1_d = buttons1_q;
    buttons2_d = buttons2_q;
    valid_d    = 1'b0;
    timer_hit  = 1'b0;

    if (tick) begin
      if (tmr_q == '0) begin
        tmr_d     = TM_LOAD;
        timer_hit = 1'b1;
      end else begin
        tmr_d = tmr_q - TM_W'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            pending_d = 1'b0;
            cnt_d     = '0;
            phase_d   = 1'b0;
            state_d   = S_LATCH;
          end
        end
        S_LATCH: begin
          if (phase_q) state_d = S_SETTLE;
          else         phase_d = 1'b1;
        end
        S_SETTLE: begin
          shift1_d[0] = ~sync1_q[1];
          shift2_d[0] = ~sync2_q[1];
          state_d     = S_CLK_LO;
        end
        S_CLK_LO: state_d = S_CLK_HI;
        S_CLK_HI: begin
          if (cnt_q < CNT_LAST) begin
            cnt_d             = nxt_idx;
            shift1_d[nxt_idx] = ~sync1_q[1];
            shift2_d[nxt_idx] = ~sync2_q[1];
            state_d           = S_CLK_LO;
          end else begin
            // The last pulse only returns the pads to idle; its data bit is not kept.
            buttons1_d = shift1_q;
            buttons2_d = shift2_q;
            valid_d    = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A new request wins over the clear of a poll that starts on the same tick.
    if (timer_hit || poll_req) pending_d = 1'b1;

    pad_latch_d = (state_d == S_LATCH);
    pad_clk_d   = (state_d != S_CLK_LO);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ps_q        <= '0;
      tmr_q       <= '0;
      pending_q   <= 1'b0;
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      phase_q     <= 1'b0;
      cnt_q       <= '0;
      shift1_q    <= '0;
      shift2_q    <= '0;
      buttons1_q  <= '0;
      buttons2_q  <= '0;
      valid_q     <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps_q        <= ps_d;
      tmr_q       <= tmr_d;
      pending_q   <= pending_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      shift1_q    <= shift1_d;
      shift2_q    <= shift2_d;
      buttons1_q  <= buttons1_d;
      buttons2_q  <= buttons2_d;
      valid_q     <= valid_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      busy_q      <= busy_d;
    end
  end

  assign pad_latch     = pad_latch_q;
  assign pad_clk       = pad_clk_q;
  assign buttons1      = buttons1_q;
  assign buttons2      = buttons2_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;

endmodule
